// File: rtl/spi_fifo_param_if.sv
// Handshake and status bundle between the SPI FIFO and its user.
// The master side writes and reads; the slave side is the FIFO itself.
interface spi_fifo_param_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          clr;
  logic [DW-1:0] din;
  logic          we;
  logic          re;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          ovf;
  logic          unf;

  modport master (
    output clr, din, we, re,
    input  dout, full, empty, count, almost_full, almost_empty, ovf, unf
  );

  modport slave (
    input  clr, din, we, re,
    output dout, full, empty, count, almost_full, almost_empty, ovf, unf
  );
endinterface

// File: rtl/spi_fifo_param.sv
// Parametrised synchronous FIFO for the SPI datapath (TX and RX instances).
// Occupancy count alone decides full/empty; pointers wrap modulo DEPTH.
// Write while full is accepted only alongside a read; no fall-through on empty.
module spi_fifo_param #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_fifo_param_if.slave       bus
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW + 1)'(AE_LVL);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic full, empty, wr_ok, rd_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A full FIFO can still take a write when a read frees a slot in the same cycle.
  assign wr_ok = bus.we & (~full | bus.re);
  assign rd_ok = bus.re & ~empty;

  // Next-state for pointers, occupancy and sticky error flags; clr flushes and drops requests.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (bus.clr) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_ok) wp_d = wp_q + 1'b1;
      if (rd_ok) rp_d = rp_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (bus.we & full & ~bus.re) ovf_d = 1'b1;
      if (bus.re & empty)          unf_d = 1'b1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage write; a request coinciding with reset or clr is discarded.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately not reset; count guards every read of stale data.
    if (rst && !bus.clr && wr_ok) mem_q[wp_q] <= bus.din;
  end

  assign bus.dout         = mem_q[rp_q];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.ovf          = ovf_q;
  assign bus.unf          = unf_q;

endmodule
